// File: rtl/trend_pattern_table_pkg.sv
// Shared constants and encodings for the trend pattern table: counter encodings,
// stat counter deltas and default sizing.
package trend_pattern_table_pkg;

    localparam int INDEX_WIDTH        = 6;
    localparam int STAT_COUNTER_WIDTH = 5;
    localparam int STAT_RESET         = 16;
    localparam int STAT_THRESHOLD     = 8;

    // Trend counter encodings, ordered from strongly not-taken to strongly taken.
    // 3'b001 is unused; the operator folds it back to the reset value.
    typedef enum logic [2:0] {
        TREND_STRONG_NT = 3'b111,
        TREND_MID_NT    = 3'b110,
        TREND_WEAK_NT   = 3'b101,
        TREND_RESET     = 3'b100,
        TREND_WEAK_T    = 3'b000,
        TREND_MID_T     = 3'b010,
        TREND_STRONG_T  = 3'b011,
        TREND_UNUSED    = 3'b001
    } trend_e;

    // Signed 3-bit deltas fed to the stat counter operator.
    localparam logic [2:0] STAT_INC = 3'b001;
    localparam logic [2:0] STAT_DEC = 3'b101;

    typedef struct packed {
        logic taken;
        logic confident;
    } trend_vote_t;

    function automatic trend_vote_t decode_trend(input logic [2:0] count);
        trend_vote_t vote;
        vote.taken     = (count == TREND_WEAK_T) || (count == TREND_MID_T) ||
                         (count == TREND_STRONG_T);
        vote.confident = (count == TREND_MID_T) || (count == TREND_STRONG_T);
        return vote;
    endfunction

endpackage

// File: rtl/trend_pattern_table_bank.sv
// Flop array of trend counters: one read-modify-write update port and one lookup
// read port that sees the same-cycle update (write-first) or a pending clear.
module trend_table_bank
    import trend_pattern_table_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   upd_en,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic [2:0]             upd_data,
    output logic [2:0]             upd_count,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic [2:0]             rd_count
);
    localparam int ENTRIES = 2 ** INDEX_WIDTH;

    logic [2:0] mem [ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= TREND_RESET;
        end else if (clear) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= TREND_RESET;
        end else if (upd_en) begin
            mem[upd_index] <= upd_data;
        end
    end

    assign upd_count = mem[upd_index];

    // A pending clear wins over the bypass, matching what the array will hold.
    always_comb begin
        rd_count = mem[rd_index];
        if (upd_en && (upd_index == rd_index)) rd_count = upd_data;
        if (clear) rd_count = TREND_RESET;
    end
endmodule

// File: rtl/trend_pattern_table_ops.sv
// Combinational helpers: trend counter decode, trend counter step and the
// saturating global stat counter step.
module trend_counter_decoder
    import trend_pattern_table_pkg::*;
(
    input  logic [2:0] count,
    output logic       taken,
    output logic       confident
);
    trend_vote_t vote;

    always_comb begin
        vote      = decode_trend(count);
        taken     = vote.taken;
        confident = vote.confident;
    end
endmodule

module trend_counter_operator
    import trend_pattern_table_pkg::*;
(
    input  logic [2:0] count,
    input  logic       dec,
    output logic [2:0] next_count
);
    // Move one step along the chain; both ends saturate.
    always_comb begin
        next_count = TREND_RESET;
        case (count)
            TREND_STRONG_NT: next_count = dec ? TREND_STRONG_NT : TREND_MID_NT;
            TREND_MID_NT:    next_count = dec ? TREND_STRONG_NT : TREND_WEAK_NT;
            TREND_WEAK_NT:   next_count = dec ? TREND_MID_NT    : TREND_RESET;
            TREND_RESET:     next_count = dec ? TREND_WEAK_NT   : TREND_WEAK_T;
            TREND_WEAK_T:    next_count = dec ? TREND_RESET     : TREND_MID_T;
            TREND_MID_T:     next_count = dec ? TREND_WEAK_T    : TREND_STRONG_T;
            TREND_STRONG_T:  next_count = dec ? TREND_MID_T     : TREND_STRONG_T;
            default:         next_count = TREND_RESET;
        endcase
    end
endmodule

module stat_counter_operator #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] count,
    input  logic [2:0]       delta,
    output logic [WIDTH-1:0] next_count,
    output logic             overflow
);
    logic signed [WIDTH+1:0] sum;
    logic signed [WIDTH+1:0] max_val;

    always_comb begin
        max_val    = $signed({2'b00, {WIDTH{1'b1}}});
        sum        = $signed({2'b00, count}) + $signed({{(WIDTH-1){delta[2]}}, delta});
        next_count = sum[WIDTH-1:0];
        overflow   = 1'b0;
        if (sum < 0) begin
            next_count = '0;
        end else if (sum > max_val) begin
            next_count = '1;
            overflow   = 1'b1;
        end
    end
endmodule

// File: rtl/trend_pattern_table.sv
// Branch-direction pattern table: registered lookup of 3-bit trend counters,
// resolution write-back and a global saturating accuracy counter.
module trend_pattern_table
    import trend_pattern_table_pkg::*;
#(
    parameter int INDEX_WIDTH        = trend_pattern_table_pkg::INDEX_WIDTH,
    parameter int STAT_COUNTER_WIDTH = trend_pattern_table_pkg::STAT_COUNTER_WIDTH,
    parameter int STAT_RESET         = trend_pattern_table_pkg::STAT_RESET,
    parameter int STAT_THRESHOLD     = trend_pattern_table_pkg::STAT_THRESHOLD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          pred_valid,
    input  logic [INDEX_WIDTH-1:0]        pred_index,
    output logic                          pred_out_valid,
    output logic [2:0]                    pred_count,
    output logic                          pred_taken,
    output logic                          pred_confident,
    input  logic                          upd_valid,
    input  logic [INDEX_WIDTH-1:0]        upd_index,
    input  logic                          upd_taken,
    input  logic                          upd_mispredict,
    output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
    output logic                          stat_of,
    output logic                          pred_use
);
    logic [2:0]                    upd_count;
    logic [2:0]                    upd_next;
    logic [2:0]                    rd_count;
    logic                          rd_taken;
    logic                          rd_confident;
    logic [STAT_COUNTER_WIDTH-1:0] stat_next;
    logic                          stat_overflow;
    logic [2:0]                    stat_delta;

    trend_table_bank #(.INDEX_WIDTH(INDEX_WIDTH)) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .upd_en    (upd_valid),
        .upd_index (upd_index),
        .upd_data  (upd_next),
        .upd_count (upd_count),
        .rd_index  (pred_index),
        .rd_count  (rd_count)
    );

    trend_counter_operator u_operator (
        .count      (upd_count),
        .dec        (~upd_taken),
        .next_count (upd_next)
    );

    trend_counter_decoder u_decoder (
        .count     (rd_count),
        .taken     (rd_taken),
        .confident (rd_confident)
    );

    assign stat_delta = upd_mispredict ? STAT_DEC : STAT_INC;

    stat_counter_operator #(.WIDTH(STAT_COUNTER_WIDTH)) u_stat_op (
        .count      (stat_count),
        .delta      (stat_delta),
        .next_count (stat_next),
        .overflow   (stat_overflow)
    );

    // Lookup results hold between requests; only the valid flag tracks pred_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_out_valid <= 1'b0;
            pred_count     <= 3'b000;
            pred_taken     <= 1'b0;
            pred_confident <= 1'b0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid) begin
                pred_count     <= rd_count;
                pred_taken     <= rd_taken;
                pred_confident <= rd_confident;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_count <= STAT_COUNTER_WIDTH'(STAT_RESET);
            stat_of    <= 1'b0;
        end else if (clear) begin
            stat_count <= STAT_COUNTER_WIDTH'(STAT_RESET);
            stat_of    <= 1'b0;
        end else if (upd_valid) begin
            stat_count <= stat_next;
            stat_of    <= stat_overflow;
        end else begin
            stat_of    <= 1'b0;
        end
    end

    assign pred_use = (stat_count >= STAT_COUNTER_WIDTH'(STAT_THRESHOLD));

endmodule

// File: tb/tb_trend_pattern_table.sv
// Self-checking bench for trend_pattern_table: vector table for lookup/update/bypass/clear,
// loops for stat saturation and overflow, and an asynchronous reset mid-lookup.
module tb_trend_pattern_table;

    typedef struct {
        logic       pv;
        logic [5:0] pidx;
        logic       uv;
        logic [5:0] uidx;
        logic       ut;
        logic       um;
        logic       clr;
        logic [2:0] exp_count;
    } vec_t;

    typedef struct {
        logic [2:0] count;
        logic       taken;
        logic       conf;
    } pred_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       pred_valid = 1'b0;
    logic [5:0] pred_index = '0;
    logic       pred_out_valid;
    logic [2:0] pred_count;
    logic       pred_taken;
    logic       pred_confident;
    logic       upd_valid = 1'b0;
    logic [5:0] upd_index = '0;
    logic       upd_taken = 1'b0;
    logic       upd_mispredict = 1'b0;
    logic [4:0] stat_count;
    logic       stat_of;
    logic       pred_use;

    int    compared = 0;
    int    mismatched = 0;
    int    exp_stat = 16;
    logic  exp_of = 1'b0;
    logic  exp_pov = 1'b0;
    pred_t last_pred = '{3'b000, 1'b0, 1'b0};
    pred_t sb[$];
    vec_t  vecs[21];

    trend_pattern_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .pred_valid     (pred_valid),
        .pred_index     (pred_index),
        .pred_out_valid (pred_out_valid),
        .pred_count     (pred_count),
        .pred_taken     (pred_taken),
        .pred_confident (pred_confident),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .stat_count     (stat_count),
        .stat_of        (stat_of),
        .pred_use       (pred_use)
    );

    always #5 clk = ~clk;

    function automatic pred_t expect_pred(input logic [2:0] c);
        pred_t p;
        p.count = c;
        p.taken = (c == 3'b000) || (c == 3'b010) || (c == 3'b011);
        p.conf  = (c == 3'b010) || (c == 3'b011);
        return p;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_output();
        pred_t p;
        check("pred_out_valid", pred_out_valid, exp_pov);
        if (pred_out_valid) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                p = sb.pop_front();
                check("pred_count", pred_count, p.count);
                check("pred_taken", pred_taken, p.taken);
                check("pred_confident", pred_confident, p.conf);
                last_pred = p;
            end
        end else begin
            check("pred_count_hold", pred_count, last_pred.count);
        end
        check("stat_count", stat_count, exp_stat);
        check("stat_of", stat_of, exp_of);
        check("pred_use", pred_use, exp_stat >= 8);
    endtask

    task automatic apply_stimulus(input vec_t v);
        pred_valid     = v.pv;
        pred_index     = v.pidx;
        upd_valid      = v.uv;
        upd_index      = v.uidx;
        upd_taken      = v.ut;
        upd_mispredict = v.um;
        clear          = v.clr;
        if (v.pv) sb.push_back(expect_pred(v.exp_count));
        exp_of  = 1'b0;
        exp_pov = v.pv;
        if (v.clr) begin
            exp_stat = 16;
        end else if (v.uv) begin
            if (v.um) exp_stat = (exp_stat < 3) ? 0 : exp_stat - 3;
            else if (exp_stat == 31) exp_of = 1'b1;
            else exp_stat = exp_stat + 1;
        end
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        clear      = 1'b0;
        check_output();
    endtask

    initial begin
        vec_t v;
        //           pv    pidx   uv    uidx   ut    um    clr   exp_count
        vecs[0]  = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b100};
        vecs[1]  = '{1'b0, 6'd0,  1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b000};
        vecs[3]  = '{1'b0, 6'd0,  1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 6'd5,  1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 3'b011};
        vecs[5]  = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b011};
        vecs[6]  = '{1'b0, 6'd0,  1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b011};
        vecs[8]  = '{1'b1, 6'd9,  1'b1, 6'd9,  1'b1, 1'b0, 1'b0, 3'b000};
        vecs[9]  = '{1'b0, 6'd0,  1'b1, 6'd7,  1'b0, 1'b1, 1'b0, 3'b000};
        vecs[10] = '{1'b1, 6'd7,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b101};
        vecs[11] = '{1'b0, 6'd0,  1'b1, 6'd7,  1'b0, 1'b1, 1'b0, 3'b000};
        vecs[12] = '{1'b0, 6'd0,  1'b1, 6'd7,  1'b0, 1'b0, 1'b0, 3'b000};
        vecs[13] = '{1'b0, 6'd0,  1'b1, 6'd7,  1'b0, 1'b0, 1'b0, 3'b000};
        vecs[14] = '{1'b1, 6'd7,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b111};
        vecs[15] = '{1'b1, 6'd9,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b000};
        vecs[16] = '{1'b0, 6'd0,  1'b1, 6'd3,  1'b1, 1'b0, 1'b0, 3'b000};
        vecs[17] = '{1'b1, 6'd3,  1'b1, 6'd3,  1'b1, 1'b0, 1'b1, 3'b100};
        vecs[18] = '{1'b1, 6'd3,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b100};
        vecs[19] = '{1'b1, 6'd9,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b100};
        vecs[20] = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 3'b000};

        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_pov = 1'b0;
        check_output();

        for (int i = 0; i < 21; i++) apply_stimulus(vecs[i]);

        // 20 mispredicts: clamps at zero, pred_use drops below threshold.
        for (int i = 0; i < 20; i++) begin
            v = '{1'b0, 6'd0, 1'b1, 6'd20, 1'b0, 1'b1, 1'b0, 3'b000};
            apply_stimulus(v);
        end
        check("stat_floor", stat_count, 0);

        v = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 3'b000};
        apply_stimulus(v);

        // 16 correct updates from 16: reaches 31, the last one overflows.
        for (int i = 0; i < 16; i++) begin
            v = '{1'b0, 6'd0, 1'b1, 6'd21, 1'b1, 1'b0, 1'b0, 3'b000};
            apply_stimulus(v);
        end
        check("stat_of_pulse", stat_of, 1);
        v = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 3'b000};
        apply_stimulus(v);
        check("stat_hold_max", stat_count, 31);

        // Lookup in flight, then asynchronous reset mid-cycle.
        pred_valid = 1'b1;
        pred_index = 6'd21;
        sb.push_back(expect_pred(3'b011));
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        exp_pov = 1'b1;
        exp_of  = 1'b0;
        check_output();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_pred_out_valid", pred_out_valid, 0);
        check("reset_pred_count", pred_count, 0);
        check("reset_stat_count", stat_count, 16);
        exp_stat  = 16;
        last_pred = '{3'b000, 1'b0, 1'b0};
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{1'b1, 6'd21, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 3'b100};
        apply_stimulus(v);

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
